seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 136 +++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed 7-segment scan driver with BCD decode, per-digit decimal
// points, optional leading-zero blanking and frame-coherent input shadowing.
module seg_scan_driver #(
    parameter int SCAN_DIV = 1,
    parameter int LZB      = 1
) (
    input  logic        clk1k,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] bcd,
    input  logic [7:0]  dp,
    output logic [7:0]  seg_com,
    output logic [7:0]  seg_data,
    output logic        frame_start
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SCAN  = 1'b1;
    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

    logic [0:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  div_q, div_d;
    logic [31:0] bcd_sh_q, bcd_sh_d;
    logic [7:0]  dp_sh_q, dp_sh_d;
    logic [7:0]  seg_com_q, seg_com_d;
    logic [7:0]  seg_data_q, seg_data_d;
    logic        frame_start_q, frame_start_d;
    logic        show;

    logic [6:0]  seg_tbl [8];
    logic [7:0]  blank_vec;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hFC;
            4'd1:    s = 8'h60;
            4'd2:    s = 8'hDA;
            4'd3:    s = 8'hF2;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'hB6;
            4'd6:    s = 8'hBE;
            4'd7:    s = 8'hE0;
            4'd8:    s = 8'hFE;
            4'd9:    s = 8'hF6;
            default: s = 8'h02;
        endcase
        return s;
    endfunction

    // Scan sequencing; shadows only ever reload at frame entry or on the 7->0 wrap.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        div_d         = div_q;
        bcd_sh_d      = bcd_sh_q;
        dp_sh_d       = dp_sh_q;
        frame_start_d = 1'b0;
        show          = 1'b0;
        if (en) begin
            show = 1'b1;
            if (state_q == ST_IDLE) begin
                state_d       = ST_SCAN;
                idx_d         = 3'd0;
                div_d         = 8'd0;
                bcd_sh_d      = bcd;
                dp_sh_d       = dp;
                frame_start_d = 1'b1;
            end else if (div_q == DIV_LAST) begin
                div_d = 8'd0;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    bcd_sh_d      = bcd;
                    dp_sh_d       = dp;
                    frame_start_d = 1'b1;
                end
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    // Decode and blanking work on the next-state shadows so the pins match the new idx.
    assign blank_vec[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            logic [7:0] code;
            assign code        = seg_decode(bcd_sh_d[4*gi +: 4]);
            assign seg_tbl[gi] = code[7:1];
            if (gi > 0) begin : g_blank
                assign blank_vec[gi] = (bcd_sh_d[31:4*gi] == '0);
            end
        end
    endgenerate

    always_comb begin
        seg_com_d  = 8'hFF;
        seg_data_d = 8'h00;
        if (show) begin
            seg_com_d = ~(8'b0000_0001 << idx_d);
            if ((LZB != 0) && blank_vec[idx_d]) begin
                seg_data_d = {7'h00, dp_sh_d[idx_d]};
            end else begin
                seg_data_d = {seg_tbl[idx_d], dp_sh_d[idx_d]};
            end
        end
    end

    always_ff @(posedge clk1k or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= 3'd0;
            div_q         <= 8'd0;
            bcd_sh_q      <= 32'd0;
            dp_sh_q       <= 8'd0;
            seg_com_q     <= 8'hFF;
            seg_data_q    <= 8'h00;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            div_q         <= div_d;
            bcd_sh_q      <= bcd_sh_d;
            dp_sh_q       <= dp_sh_d;
            seg_com_q     <= seg_com_d;
            seg_data_q    <= seg_data_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg_com     = seg_com_q;
    assign seg_data    = seg_data_q;
    assign frame_start = frame_start_q;

endmodule
